// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-754 floating-point adder/subtractor.
// Stage 1 unpacks, swaps and aligns; stage 2 adds; stage 3 normalises,
// rounds to nearest-even and registers result/flags. A single global
// advance signal stalls every stage when the output is held.
module fp_addsub_pipe #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  input  logic         add_or_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  localparam int STAGES = 3;
  // Significand field: hidden, fraction, guard, round, sticky.
  localparam int F  = MAN_W + 4;
  localparam int RW = EXP_W + MAN_W + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF} sp_e;

  typedef struct packed {
    sp_e              sp;
    logic             sp_sign;
    logic             sp_inv;
    logic             sign_l;
    logic             sign_s;
    logic [EXP_W-1:0] exp_l;
    logic [F-1:0]     sig_l;
    logic [F-1:0]     sig_s;
  } s1_t;

  typedef struct packed {
    sp_e              sp;
    logic             sp_sign;
    logic             sp_inv;
    logic             sign;
    logic             zsign;
    logic [EXP_W-1:0] exp_l;
    logic [F:0]       sum;
  } s2_t;

  logic [STAGES:0] vld_pipe;
  logic            advance;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    res_d;
  logic [2:0]      flg_d;

  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];
  assign advance     = ~out_valid | out_ready;
  assign in_ready    = advance;

  // Leading-zero count; an all-zero input returns F.
  function automatic logic [EXP_W-1:0] lzc(input logic [F-1:0] v);
    lzc = EXP_W'(F);
    for (int i = 0; i < F; i++)
      if (v[i]) lzc = EXP_W'(F - 1 - i);
  endfunction

  // ---------------- stage 1: unpack, classify, swap, align ----------------
  logic [EXP_W-1:0] ea, eb, el, es, el_eff, es_eff, diff;
  logic [MAN_W-1:0] fa, fb, fl, fs;
  logic             sa, sb, swap;
  logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic [F-1:0]     sig_s_full, sh;

  // Order operands by magnitude and shift the smaller one into place.
  always_comb begin
    s1_d       = '0;
    ea         = a_operand[W-2:MAN_W];
    eb         = b_operand[W-2:MAN_W];
    fa         = a_operand[MAN_W-1:0];
    fb         = b_operand[MAN_W-1:0];
    sa         = a_operand[W-1];
    sb         = b_operand[W-1] ^ add_or_sub;
    swap       = b_operand[W-2:0] > a_operand[W-2:0];
    el         = swap ? eb : ea;
    es         = swap ? ea : eb;
    fl         = swap ? fb : fa;
    fs         = swap ? fa : fb;
    // Subnormals behave as exponent 1 with a zero hidden bit.
    el_eff     = (el == '0) ? EXP_W'(1) : el;
    es_eff     = (es == '0) ? EXP_W'(1) : es;
    diff       = el_eff - es_eff;
    sig_s_full = {|es, fs, 3'b000};
    sh         = sig_s_full >> diff;
    if (diff >= EXP_W'(F))
      s1_d.sig_s = {{(F-1){1'b0}}, |sig_s_full};
    else
      s1_d.sig_s = sh | {{(F-1){1'b0}}, ((sh << diff) != sig_s_full)};
    s1_d.sig_l  = {|el, fl, 3'b000};
    s1_d.exp_l  = el_eff;
    s1_d.sign_l = swap ? sb : sa;
    s1_d.sign_s = swap ? sa : sb;

    a_nan  = (ea == EMAX) && (fa != '0);
    b_nan  = (eb == EMAX) && (fb != '0);
    a_inf  = (ea == EMAX) && (fa == '0);
    b_inf  = (eb == EMAX) && (fb == '0);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
    s1_d.sp = SP_NONE;
    if (a_nan || b_nan) begin
      s1_d.sp     = SP_NAN;
      s1_d.sp_inv = a_snan | b_snan;
    end else if (a_inf && b_inf && (sa != sb)) begin
      s1_d.sp     = SP_NAN;
      s1_d.sp_inv = 1'b1;
    end else if (a_inf) begin
      s1_d.sp      = SP_INF;
      s1_d.sp_sign = sa;
    end else if (b_inf) begin
      s1_d.sp      = SP_INF;
      s1_d.sp_sign = sb;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else if (advance) s1_q <= s1_d;
  end

  // ---------------- stage 2: add / subtract ----------------
  // Larger magnitude is first, so an effective subtract never goes negative.
  always_comb begin
    s2_d         = '0;
    s2_d.sp      = s1_q.sp;
    s2_d.sp_sign = s1_q.sp_sign;
    s2_d.sp_inv  = s1_q.sp_inv;
    s2_d.sign    = s1_q.sign_l;
    // Exact zero is -0 only when both effective signs are negative.
    s2_d.zsign   = s1_q.sign_l & s1_q.sign_s;
    s2_d.exp_l   = s1_q.exp_l;
    if (s1_q.sign_l != s1_q.sign_s)
      s2_d.sum = {1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s};
    else
      s2_d.sum = {1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s};
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_q <= '0;
    else if (advance) s2_q <= s2_d;
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [EXP_W-1:0] lz, lim, shamt, e, e_fld;
  logic [F-1:0]     m;
  logic             rup, ovf;
  logic [RW-1:0]    rnd;

  // Normalise, then round by adding into {exp,frac} so carries renormalise.
  always_comb begin
    res_d = '0;
    flg_d = '0;
    lz    = lzc(s2_q.sum[F-1:0]);
    lim   = s2_q.exp_l - EXP_W'(1);
    shamt = (lz < lim) ? lz : lim;
    if (s2_q.sum[F]) begin
      m = {s2_q.sum[F:2], |s2_q.sum[1:0]};
      e = s2_q.exp_l + EXP_W'(1);
    end else begin
      m = s2_q.sum[F-1:0] << shamt;
      e = s2_q.exp_l - shamt;
    end
    // A limited shift leaves the hidden bit clear: subnormal encoding.
    e_fld = m[F-1] ? e : '0;
    rup   = m[2] & (m[3] | m[1] | m[0]);
    rnd   = {1'b0, e_fld, m[F-2:3]} + RW'(rup);
    ovf   = rnd[RW-1] | (rnd[RW-2:MAN_W] == EMAX);
    case (s2_q.sp)
      SP_NAN: begin
        res_d = QNAN;
        flg_d = {s2_q.sp_inv, 2'b00};
      end
      SP_INF: res_d = {s2_q.sp_sign, EMAX, {MAN_W{1'b0}}};
      default: begin
        if (s2_q.sum == '0) begin
          res_d = {s2_q.zsign, {(W-1){1'b0}}};
        end else if (ovf) begin
          res_d = {s2_q.sign, EMAX, {MAN_W{1'b0}}};
          flg_d = 3'b011;
        end else begin
          res_d = {s2_q.sign, rnd[RW-2:0]};
          flg_d = {2'b00, |m[2:0]};
        end
      end
    endcase
  end

  // Output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (advance) begin
      result <= res_d;
      flags  <= flg_d;
    end
  end

  // Valid shift register; bubbles travel as zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else if (advance) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (binary64): directed vectors with literal
// expectations, a real-arithmetic reference model for random traffic,
// backpressure, latency and mid-flight reset checks.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a_operand = '0;
  logic [63:0] b_operand = '0;
  logic        add_or_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic [2:0]  flags;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] sb_r[$];
  logic [2:0]  sb_f[$];

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  localparam int ND = 13;
  logic [63:0] da [ND] = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
                           64'h3FF0000000000000, 64'h7FF0000000000000, 64'h7FF0000000000001,
                           64'hFFF0000000000000, 64'h7FEFFFFFFFFFFFFF, 64'h0000000000000001,
                           64'h0010000000000000, 64'h8000000000000000, 64'h8000000000000000,
                           64'h3FF0000000000000};
  logic [63:0] db [ND] = '{64'h4000000000000000, 64'h3FF0000000000000, 64'h3CA0000000000000,
                           64'h3CA8000000000000, 64'h7FF0000000000000, 64'h3FF0000000000000,
                           64'h4000000000000000, 64'h7FEFFFFFFFFFFFFF, 64'h0000000000000001,
                           64'h0000000000000001, 64'h8000000000000000, 64'h0000000000000000,
                           64'hBFF0000000000000};
  logic [ND-1:0] dop = 13'b0_1010_0001_0010;
  logic [63:0] dr [ND] = '{64'h4008000000000000, 64'h0000000000000000, 64'h3FF0000000000000,
                           64'h3FF0000000000001, 64'h7FF8000000000000, 64'h7FF8000000000000,
                           64'hFFF0000000000000, 64'h7FF0000000000000, 64'h0000000000000002,
                           64'h000FFFFFFFFFFFFF, 64'h8000000000000000, 64'h8000000000000000,
                           64'h0000000000000000};
  logic [2:0]  df [ND] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 3'd4, 3'd0, 3'd3, 3'd0, 3'd0,
                           3'd0, 3'd0, 3'd0};

  fp_addsub_pipe #(.EXP_W(11), .MAN_W(52)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .add_or_sub(add_or_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction
  function automatic logic is_snan(input logic [63:0] x);
    return is_nan(x) && !x[51];
  endfunction
  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
  endfunction

  // Reference: host double arithmetic gives the RNE result; the TwoSum
  // error term tells whether it was exact.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic op,
                                output logic [63:0] r, output logic [2:0] f);
    logic [63:0] bb;
    real ra, rb, s, bv, av, err;
    bb = b ^ {op, 63'd0};
    r  = '0;
    f  = '0;
    if (is_nan(a) || is_nan(b)) begin
      r = QNAN;
      f = {is_snan(a) | is_snan(b), 2'b00};
    end else begin
      ra = $bitstoreal(a);
      rb = $bitstoreal(bb);
      s  = ra + rb;
      r  = $realtobits(s);
      if (is_nan(r)) begin
        r = QNAN;
        f = 3'b100;
      end else if (is_inf(a) || is_inf(bb)) begin
        f = 3'b000;
      end else if (is_inf(r)) begin
        f = 3'b011;
      end else begin
        bv  = s - ra;
        av  = s - bv;
        err = (ra - av) + (rb - bv);
        f   = {2'b00, err != 0.0};
      end
    end
  endfunction

  // Operand near a chosen exponent, with a share of subnormals, specials
  // and huge values.
  function automatic logic [63:0] rnd_op(input logic [10:0] near);
    logic [63:0] x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: x[62:52] = 11'd0;
      1: case ($urandom_range(0, 3))
           0:       x[62:0] = {11'h7FF, 52'd0};
           1:       x[62:0] = {11'h7FF, 1'b1, x[50:0]};
           2:       x[62:0] = {11'h7FF, 1'b0, x[50:1], 1'b1};
           default: x[62:0] = '0;
         endcase
      2: x[62:52] = 11'h7FE - 11'($urandom_range(0, 1));
      default: x[62:52] = near + 11'($urandom_range(0, 4)) - 11'd2;
    endcase
    return x;
  endfunction

  // One clock: drive at +1, sample handshake and outputs at +4.
  task automatic cycle(input logic iv, input logic [63:0] a, input logic [63:0] b,
                       input logic op, input logic ordy, output logic acc);
    logic [63:0] er;
    logic [2:0]  ef;
    @(posedge clk);
    #1;
    in_valid   = iv;
    a_operand  = a;
    b_operand  = b;
    add_or_sub = op;
    out_ready  = ordy;
    #3;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("pop_expected", 64'(sb_r.size() != 0), 64'd1);
      if (sb_r.size() != 0) begin
        er = sb_r.pop_front();
        ef = sb_f.pop_front();
        chk("result", result, er);
        chk("flags", 64'(flags), 64'(ef));
      end
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic op,
                       input logic [63:0] er, input logic [2:0] ef, input logic ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, a, b, op, ordy, acc);
      n++;
    end
    chk("accept", 64'(acc), 64'd1);
    if (acc) begin
      sb_r.push_back(er);
      sb_f.push_back(ef);
    end
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (sb_r.size() != 0 && n < 100) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", 64'(sb_r.size()), 64'd0);
  endtask

  initial begin
    logic        acc, op, iv, ordy;
    logic [63:0] a, b, er, held;
    logic [2:0]  ef;
    logic [63:0] bpa [16];
    logic [63:0] bpb [16];
    logic        bpo [16];
    int          idx, lat, guard;

    // Reset state.
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Latency of 1.0 + 2.0 through an empty pipe.
    cycle(1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 1'b1, acc);
    chk("lat_accept", 64'(acc), 64'd1);
    if (acc) begin
      sb_r.push_back(64'h4008000000000000);
      sb_f.push_back(3'b000);
    end
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      lat++;
      if (out_valid) break;
    end
    chk("latency", 64'(lat), 64'd3);
    drain();

    // Directed vectors.
    for (int i = 0; i < ND; i++)
      issue(da[i], db[i], dop[i], dr[i], df[i], 1'b1);
    drain();

    // Backpressure: five operations against a stalled consumer.
    for (int i = 0; i < 16; i++) begin
      bpa[i] = rnd_op(11'($urandom_range(1000, 1040)));
      bpb[i] = rnd_op(bpa[i][62:52]);
      bpo[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, bpa[idx], bpb[idx], bpo[idx], 1'b0, acc);
      if (acc) begin
        model(bpa[idx], bpb[idx], bpo[idx], er, ef);
        sb_r.push_back(er);
        sb_f.push_back(ef);
        idx++;
      end
    end
    chk("bp_accepted", 64'(idx), 64'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    held = result;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, bpa[idx], bpb[idx], bpo[idx], 1'b0, acc);
      chk("bp_no_accept", 64'(acc), 64'd0);
      chk("bp_stable", result, held);
    end
    guard = 0;
    while (idx < 5 && guard < 50) begin
      cycle(1'b1, bpa[idx], bpb[idx], bpo[idx], 1'b1, acc);
      if (acc) begin
        model(bpa[idx], bpb[idx], bpo[idx], er, ef);
        sb_r.push_back(er);
        sb_f.push_back(ef);
        idx++;
      end
      guard++;
    end
    chk("bp_all_issued", 64'(idx), 64'd5);
    drain();

    // Asynchronous reset with two operations in flight.
    issue(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000, 3'b000, 1'b1);
    issue(64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000, 3'b000, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_flags", 64'(flags), 64'd0);
    sb_r.delete();
    sb_f.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end

    // Random traffic with random bubbles and stalls.
    for (int i = 0; i < 600; i++) begin
      a    = rnd_op(11'($urandom_range(1, 2046)));
      b    = rnd_op(a[62:52]);
      op   = 1'($urandom_range(0, 1));
      iv   = ($urandom_range(0, 4) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(iv, a, b, op, ordy, acc);
      if (acc) begin
        model(a, b, op, er, ef);
        sb_r.push_back(er);
        sb_f.push_back(ef);
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
